bus_split_arbiter: RTL and testbench

- Arbitrates the shared serial bus between two masters and tracks split transactions.
- Sits between the master request/grant pins and the slave split/resume pins.
- Grants with fixed priority: master 0 wins over master 1.
- Masks a split master until its slave signals resume, then re-grants it ahead of new requests.
- Revokes grants that are never used.

---
 rtl/bus_split_arbiter.sv | 130 +++++++++++++
 tb/tb_bus_split_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bus_split_arbiter.sv
// Two-master fixed-priority bus arbiter. It tracks one outstanding split transaction
// and revokes any grant that is not used within TIMEOUT_CYC cycles.
module bus_split_arbiter #(
  parameter int TIMEOUT_CYC = 8,
  parameter int CNT_W       = 4
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic [1:0] B_REQ,
  input  logic       B_UTIL,
  input  logic       B_DONE,
  input  logic       B_SPLIT,
  input  logic       B_SPL_RESUME,
  output logic [1:0] B_GRANT,
  output logic       SPLIT_ACTIVE,
  output logic       SPLIT_MID,
  output logic       ARB_TIMEOUT,
  output logic       ARB_ERR
);

  typedef enum logic [1:0] {IDLE, GRANT_WAIT, BUSY} state_t;

  state_t             state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               split_active_q, split_active_d;
  logic               split_mid_q, split_mid_d;
  logic               resume_pend_q, resume_pend_d;
  logic               timeout_q, timeout_d;
  logic               err_q, err_d;
  logic [1:0]         req_eff;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q        <= IDLE;
      grant_q        <= 2'b00;
      cnt_q          <= '0;
      split_active_q <= 1'b0;
      split_mid_q    <= 1'b0;
      resume_pend_q  <= 1'b0;
      timeout_q      <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      cnt_q          <= cnt_d;
      split_active_q <= split_active_d;
      split_mid_q    <= split_mid_d;
      resume_pend_q  <= resume_pend_d;
      timeout_q      <= timeout_d;
      err_q          <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    cnt_d          = cnt_q;
    split_active_d = split_active_q;
    split_mid_d    = split_mid_q;
    resume_pend_d  = resume_pend_q;
    timeout_d      = 1'b0;
    err_d          = 1'b0;

    // Resume is sampled against the registered split flag, so a resume that
    // coincides with the split it would belong to is dropped.
    if (B_SPL_RESUME && split_active_q) resume_pend_d = 1'b1;

    req_eff = B_REQ;
    if (split_active_q && !resume_pend_q) req_eff[split_mid_q] = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (resume_pend_q) begin
          grant_d        = split_mid_q ? 2'b10 : 2'b01;
          split_active_d = 1'b0;
          resume_pend_d  = 1'b0;
          state_d        = GRANT_WAIT;
        end else if (req_eff[0]) begin
          grant_d = 2'b01;
          state_d = GRANT_WAIT;
        end else if (req_eff[1]) begin
          grant_d = 2'b10;
          state_d = GRANT_WAIT;
        end
      end
      GRANT_WAIT: begin
        if (B_UTIL) begin
          cnt_d   = '0;
          state_d = BUSY;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          grant_d   = 2'b00;
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BUSY: begin
        // A split takes precedence over a done sampled in the same cycle.
        if (B_SPLIT) begin
          if (!split_active_q) begin
            split_active_d = 1'b1;
            split_mid_d    = grant_q[1];
          end else begin
            err_d = 1'b1;
          end
          grant_d = 2'b00;
          state_d = IDLE;
        end else if (B_DONE) begin
          grant_d = 2'b00;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  assign B_GRANT      = grant_q;
  assign SPLIT_ACTIVE = split_active_q;
  assign SPLIT_MID    = split_mid_q;
  assign ARB_TIMEOUT  = timeout_q;
  assign ARB_ERR      = err_q;

endmodule

// File: tb/tb_bus_split_arbiter.sv
// Bench for bus_split_arbiter: directed scenarios followed by random traffic.
// Every cycle is compared against a grant/owner-level reference model.
module tb_bus_split_arbiter;
  localparam int TO = 8;

  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic [1:0] B_REQ = 2'b00;
  logic       B_UTIL = 1'b0, B_DONE = 1'b0, B_SPLIT = 1'b0, B_SPL_RESUME = 1'b0;
  logic [1:0] B_GRANT;
  logic       SPLIT_ACTIVE, SPLIT_MID, ARB_TIMEOUT, ARB_ERR;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state, kept at the level of owners and events.
  int m_owner = -1;  // granted master, -1 when none
  int m_split = -1;  // split master, -1 when none
  bit m_used  = 0;   // owner has started driving the bus
  int m_age   = 0;   // cycles the owner has held an unused grant
  bit m_res   = 0;
  bit m_to    = 0;
  bit m_err   = 0;

  bus_split_arbiter #(.TIMEOUT_CYC(TO), .CNT_W(4)) dut (
    .CLK(CLK), .RSTN(RSTN), .B_REQ(B_REQ), .B_UTIL(B_UTIL), .B_DONE(B_DONE),
    .B_SPLIT(B_SPLIT), .B_SPL_RESUME(B_SPL_RESUME), .B_GRANT(B_GRANT),
    .SPLIT_ACTIVE(SPLIT_ACTIVE), .SPLIT_MID(SPLIT_MID),
    .ARB_TIMEOUT(ARB_TIMEOUT), .ARB_ERR(ARB_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_split = -1; m_used = 0; m_age = 0; m_res = 0; m_to = 0; m_err = 0;
  endtask

  task automatic model_update();
    bit res_n;
    bit found;
    m_to  = 0;
    m_err = 0;
    res_n = m_res || (m_split >= 0 && B_SPL_RESUME);
    if (m_owner < 0) begin
      m_used = 0;
      m_age  = 0;
      if (m_res) begin
        m_owner = m_split;
        m_split = -1;
        res_n   = 0;
      end else begin
        found = 0;
        for (int i = 0; i < 2; i++)
          if (!found && B_REQ[i] && !(m_split == i)) begin
            m_owner = i;
            found   = 1;
          end
      end
    end else if (!m_used) begin
      if (B_UTIL) m_used = 1;
      else if (m_age == TO - 1) begin m_owner = -1; m_to = 1; end
      else m_age++;
    end else if (B_SPLIT) begin
      if (m_split < 0) m_split = m_owner;
      else m_err = 1;
      m_owner = -1;
    end else if (B_DONE) begin
      m_owner = -1;
    end
    m_res = res_n;
  endtask

  task automatic check_all();
    chk("grant", {2'b00, B_GRANT}, (m_owner < 0) ? 4'd0 : 4'(1 << m_owner));
    chk("split_active", {3'b000, SPLIT_ACTIVE}, {3'b000, m_split >= 0});
    if (m_split >= 0) chk("split_mid", {3'b000, SPLIT_MID}, 4'(m_split));
    chk("arb_timeout", {3'b000, ARB_TIMEOUT}, {3'b000, m_to});
    chk("arb_err", {3'b000, ARB_ERR}, {3'b000, m_err});
  endtask

  task automatic step(input logic [1:0] req, input logic util, input logic done,
                      input logic split, input logic res);
    B_REQ = req; B_UTIL = util; B_DONE = done; B_SPLIT = split; B_SPL_RESUME = res;
    @(posedge CLK);
    if (RSTN) model_update();
    @(negedge CLK);
    check_all();
  endtask

  initial begin
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    chk("reset_grant", {2'b00, B_GRANT}, 4'd0);
    chk("reset_outs", {SPLIT_ACTIVE, SPLIT_MID, ARB_TIMEOUT, ARB_ERR}, 4'd0);
    RSTN = 1'b1;

    // Priority: both request, master 0 wins; one idle cycle before master 1.
    step(2'b11, 0, 0, 0, 0);
    chk("prio_m0", {2'b00, B_GRANT}, 4'b0001);
    step(2'b10, 1, 0, 0, 0);
    step(2'b10, 1, 0, 0, 0);
    step(2'b10, 1, 0, 0, 0);
    step(2'b10, 1, 1, 0, 0);
    chk("turnaround", {2'b00, B_GRANT}, 4'b0000);
    step(2'b10, 0, 0, 0, 0);
    chk("prio_m1", {2'b00, B_GRANT}, 4'b0010);
    step(2'b10, 1, 0, 0, 0);
    step(2'b00, 1, 1, 0, 0);

    // Split on master 0, then master 1 owns the bus while master 0 is masked.
    step(2'b11, 0, 0, 0, 0);
    step(2'b11, 1, 0, 0, 0);
    step(2'b11, 1, 0, 1, 0);
    chk("split_set", {B_GRANT, SPLIT_ACTIVE, SPLIT_MID}, 4'b0010);
    for (int i = 0; i < 10; i++) step(2'b11, 1, 0, 0, 0);
    chk("masked_m1", {2'b00, B_GRANT}, 4'b0010);

    // Resume while master 1 is busy; master 0 re-granted after the turnaround.
    step(2'b11, 1, 0, 0, 1);
    chk("resume_no_change", {2'b00, B_GRANT}, 4'b0010);
    step(2'b10, 1, 1, 0, 0);
    step(2'b10, 0, 0, 0, 0);
    chk("resumed_grant", {B_GRANT, SPLIT_ACTIVE, 1'b0}, 4'b0100);
    step(2'b00, 1, 0, 0, 0);
    step(2'b00, 1, 1, 0, 0);

    // Timeout: an unused grant lasts exactly TO cycles.
    step(2'b01, 0, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) step(2'b01, 0, 0, 0, 0);
    chk("grant_last", {2'b00, B_GRANT}, 4'b0001);
    step(2'b01, 0, 0, 0, 0);
    chk("timeout_pulse", {B_GRANT, ARB_TIMEOUT, 1'b0}, 4'b0010);
    step(2'b01, 0, 0, 0, 0);
    chk("regrant", {B_GRANT, ARB_TIMEOUT, 1'b0}, 4'b0100);

    // Double split: the second split reports ARB_ERR and keeps SPLIT_MID.
    step(2'b01, 1, 0, 0, 0);
    step(2'b10, 1, 0, 1, 0);
    step(2'b10, 0, 0, 0, 0);
    step(2'b10, 1, 0, 0, 0);
    step(2'b00, 1, 0, 1, 0);
    chk("double_split", {ARB_ERR, SPLIT_ACTIVE, SPLIT_MID, 1'b0}, 4'b1100);
    step(2'b00, 0, 0, 0, 1);
    step(2'b00, 0, 0, 0, 0);
    chk("resume_no_req", {2'b00, B_GRANT}, 4'b0001);
    // Split and done in the same cycle: the split wins. The resume pulse in the
    // same cycle is dropped.
    step(2'b00, 1, 0, 0, 0);
    step(2'b00, 1, 1, 1, 1);
    chk("split_and_done", {B_GRANT, SPLIT_ACTIVE, 1'b0}, 4'b0010);
    step(2'b00, 0, 0, 0, 0);
    chk("resume_dropped", {2'b00, B_GRANT}, 4'b0000);

    // Asynchronous reset in the middle of a busy transfer.
    step(2'b10, 0, 0, 0, 0);
    step(2'b10, 1, 0, 0, 0);
    #2 RSTN = 1'b0;
    #1;
    chk("async_rst_grant", {2'b00, B_GRANT}, 4'd0);
    chk("async_rst_outs", {SPLIT_ACTIVE, ARB_TIMEOUT, ARB_ERR, 1'b0}, 4'd0);
    model_reset();
    @(negedge CLK);
    RSTN = 1'b1;
    step(2'b10, 0, 0, 0, 0);
    chk("post_rst_grant", {2'b00, B_GRANT}, 4'b0010);

    // Random traffic: busy-heavy first, then mostly idle bus to force timeouts.
    for (int i = 0; i < 600; i++)
      step(2'($urandom_range(0, 3)), $urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
    for (int i = 0; i < 600; i++)
      step(2'($urandom_range(0, 3)), $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
